seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a double-buffered display word,
// per-digit blanking and a one-cycle dark guard between digit slots.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_blank,
    output logic                    load_ready,
    output logic [3:0]              digit_nib,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [DATA_W-1:0]     DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] MASK_ZERO = {NUM_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SCAN  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t                  state_r;
    logic [IDX_W-1:0]        idx_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    pending_r;
    logic [DATA_W-1:0]       shadow_data_r;
    logic [NUM_DIGITS-1:0]   shadow_blank_r;
    logic [DATA_W-1:0]       active_data_r;
    logic [NUM_DIGITS-1:0]   active_blank_r;

    state_t                  state_nxt_s;
    logic [IDX_W-1:0]        idx_nxt_s;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic                    pending_nxt_s;
    logic [DATA_W-1:0]       shadow_data_nxt_s;
    logic [NUM_DIGITS-1:0]   shadow_blank_nxt_s;
    logic [DATA_W-1:0]       active_data_nxt_s;
    logic [NUM_DIGITS-1:0]   active_blank_nxt_s;
    logic                    frame_nxt_s;
    logic [NUM_DIGITS-1:0]   sel_nxt_s;
    logic [3:0]              nib_nxt_s;
    logic                    xfer_s;
    logic                    tick_s;

    function automatic logic [3:0] nib_at(input logic [DATA_W-1:0] data,
                                          input logic [IDX_W-1:0]  idx);
        logic [3:0] nib;
        nib = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = (idx == IDX_W'(i)) ? data[4*i +: 4] : nib;
        end
        return nib;
    endfunction

    // Active-low anode pattern: only the indexed digit lights, and only if not blanked.
    function automatic logic [NUM_DIGITS-1:0] sel_for(input logic [IDX_W-1:0]      idx,
                                                      input logic [NUM_DIGITS-1:0] blank);
        logic [NUM_DIGITS-1:0] sel;
        sel = SEL_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel[i] = (idx != IDX_W'(i)) || blank[i];
        end
        return sel;
    endfunction

    assign load_ready = ~pending_r;
    assign xfer_s     = load_valid & ~pending_r;
    assign tick_s     = (cnt_r == CNT_MAX);

    // Next-state, buffer and registered-output precomputation.
    always_comb begin
        state_nxt_s        = state_r;
        idx_nxt_s          = idx_r;
        cnt_nxt_s          = cnt_r;
        pending_nxt_s      = pending_r;
        shadow_data_nxt_s  = shadow_data_r;
        shadow_blank_nxt_s = shadow_blank_r;
        active_data_nxt_s  = active_data_r;
        active_blank_nxt_s = active_blank_r;
        frame_nxt_s        = 1'b0;

        case (state_r)
            EMPTY: begin
                cnt_nxt_s = CNT_ZERO;
                idx_nxt_s = IDX_ZERO;
                // Nothing is on display yet, so the first word bypasses the shadow.
                if (xfer_s) begin
                    state_nxt_s        = SCAN;
                    active_data_nxt_s  = load_data;
                    active_blank_nxt_s = load_blank;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            SCAN: begin
                if (tick_s) begin
                    state_nxt_s = GUARD;
                    cnt_nxt_s   = CNT_ZERO;
                    frame_nxt_s = (idx_r == LAST_IDX);
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
                if (xfer_s) begin
                    shadow_data_nxt_s  = load_data;
                    shadow_blank_nxt_s = load_blank;
                    pending_nxt_s      = 1'b1;
                end else begin
                    pending_nxt_s = pending_r;
                end
            end
            GUARD: begin
                state_nxt_s = SCAN;
                cnt_nxt_s   = CNT_ZERO;
                // Frame wrap: the only point where a pending word reaches the display.
                if (idx_r == LAST_IDX) begin
                    idx_nxt_s = IDX_ZERO;
                    if (pending_r) begin
                        active_data_nxt_s  = shadow_data_r;
                        active_blank_nxt_s = shadow_blank_r;
                        pending_nxt_s      = 1'b0;
                    end else begin
                        pending_nxt_s = pending_r;
                    end
                end else begin
                    idx_nxt_s = idx_r + IDX_W'(1);
                end
                if (xfer_s) begin
                    shadow_data_nxt_s  = load_data;
                    shadow_blank_nxt_s = load_blank;
                    pending_nxt_s      = 1'b1;
                end else begin
                    shadow_data_nxt_s = shadow_data_nxt_s;
                end
            end
            default: begin
                state_nxt_s   = EMPTY;
                idx_nxt_s     = IDX_ZERO;
                cnt_nxt_s     = CNT_ZERO;
                pending_nxt_s = 1'b0;
            end
        endcase

        if (state_nxt_s == SCAN) begin
            sel_nxt_s = sel_for(idx_nxt_s, active_blank_nxt_s);
        end else begin
            sel_nxt_s = SEL_OFF;
        end

        if (state_nxt_s == EMPTY) begin
            nib_nxt_s = 4'd0;
        end else begin
            nib_nxt_s = nib_at(active_data_nxt_s, idx_nxt_s);
        end
    end

    // State, buffers and registered outputs; reset discards all display data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= EMPTY;
            idx_r          <= IDX_ZERO;
            cnt_r          <= CNT_ZERO;
            pending_r      <= 1'b0;
            shadow_data_r  <= DATA_ZERO;
            shadow_blank_r <= MASK_ZERO;
            active_data_r  <= DATA_ZERO;
            active_blank_r <= MASK_ZERO;
            digit_sel      <= SEL_OFF;
            digit_nib      <= 4'd0;
            frame_done     <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            idx_r          <= idx_nxt_s;
            cnt_r          <= cnt_nxt_s;
            pending_r      <= pending_nxt_s;
            shadow_data_r  <= shadow_data_nxt_s;
            shadow_blank_r <= shadow_blank_nxt_s;
            active_data_r  <= active_data_nxt_s;
            active_blank_r <= active_blank_nxt_s;
            digit_sel      <= sel_nxt_s;
            digit_nib      <= nib_nxt_s;
            frame_done     <= frame_nxt_s;
        end
    end

endmodule
